// File: rtl/vslc_input_conditioner.sv
// vslc_input_conditioner
//
// Input conditioning stage in front of the VSLC core's ui_in bus. Eight raw
// asynchronous inputs are polarity-corrected and synchronised to clk through
// two flops. Each bit is then debounced against a shared slow tick. The block
// presents the clean levels plus one-cycle rise/fall pulses.
//
// Parameters:
//   TICK_DIV      clk cycles per debounce tick (>=1; 1 = tick every cycle)
//   STABLE_TICKS  consecutive disagreeing ticks needed to accept a new level (>=1)
//   INVERT_MASK   bit i set = raw_in[i] is active-low, inverted before sync
//
// Ports:
//   clk        single clock for the whole block
//   rst        synchronous, active-high reset
//   raw_in     [7:0] asynchronous raw inputs
//   out_level  [7:0] debounced, polarity-corrected levels (drives ui_in)
//   rise       [7:0] one-cycle pulse when out_level[i] goes 0->1
//   fall       [7:0] one-cycle pulse when out_level[i] goes 1->0
//   tick       debounce tick strobe (exported for debug)
module vslc_input_conditioner #(
  parameter int unsigned TICK_DIV     = 12000,
  parameter int unsigned STABLE_TICKS = 8,
  parameter logic [7:0]  INVERT_MASK  = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_in,
  output logic [7:0] out_level,
  output logic [7:0] rise,
  output logic [7:0] fall,
  output logic       tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW = $clog2(STABLE_TICKS) + 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [PW-1:0] pre_cnt;
  logic [7:0]    s1;
  logic [7:0]    s2;
  logic [CW-1:0] cnt [8];

  // Prescaler: tick is registered, so it rises on the TICK_DIV-th edge after
  // reset release and stays high for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
      tick    <= 1'b0;
    end
  end

  // Polarity correction happens ahead of the first flop, so the rest of the
  // block only ever sees active-high data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw_in ^ INVERT_MASK;
      s2 <= s1;
    end
  end

  // Per-channel debounce. Any cycle where the input agrees with the current
  // level throws away the accumulated count, which rejects glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_level <= '0;
      rise      <= '0;
      fall      <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      rise <= '0;
      fall <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        if (s2[i] == out_level[i]) begin
          cnt[i] <= '0;
        end else if (tick && (cnt[i] == CNT_LAST)) begin
          out_level[i] <= s2[i];
          cnt[i]       <= '0;
          rise[i]      <= s2[i];
          fall[i]      <= ~s2[i];
        end else if (tick) begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vslc_input_conditioner.sv
module tb_vslc_input_conditioner;

  typedef struct packed {
    logic [7:0] lvl;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [7:0] raw_a, raw_b;
  logic [7:0] lvl_a, rise_a, fall_a;
  logic [7:0] lvl_b, rise_b, fall_b;
  logic       tick_a, tick_b;

  int vectors = 0;
  int miscompares = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  // Configuration A: tick every cycle, 4 stable ticks.
  vslc_input_conditioner #(
    .TICK_DIV(1),
    .STABLE_TICKS(4),
    .INVERT_MASK(8'h01)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .raw_in(raw_a),
    .out_level(lvl_a),
    .rise(rise_a),
    .fall(fall_a),
    .tick(tick_a)
  );

  // Configuration B: tick every 5 cycles, 3 stable ticks.
  vslc_input_conditioner #(
    .TICK_DIV(5),
    .STABLE_TICKS(3),
    .INVERT_MASK(8'h01)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .raw_in(raw_b),
    .out_level(lvl_b),
    .rise(rise_b),
    .fall(fall_b),
    .tick(tick_b)
  );

  // Reference model state, one slot per configuration.
  // seen1/seen2: masked raw values captured one and two edges ago.
  // run: ticks observed while the delayed input has continuously disagreed
  //      with the accepted level.
  // edges: clock edges since reset release; the tick output is high after
  //      every edge whose count is a multiple of the divider.
  logic [7:0]  seen1 [2];
  logic [7:0]  seen2 [2];
  logic [7:0]  level [2];
  int unsigned edges [2];
  int unsigned run   [2][8];

  task automatic model_edge(input int id, input int unsigned td, input int unsigned st,
                            input logic [7:0] mask, input logic [7:0] raw, input logic r,
                            output exp_t e);
    logic       tick_now;
    logic [7:0] nl;
    e = '0;
    if (r) begin
      seen1[id] = '0;
      seen2[id] = '0;
      level[id] = '0;
      edges[id] = 0;
      for (int ch = 0; ch < 8; ch++) run[id][ch] = 0;
    end else begin
      tick_now = (edges[id] != 0) && ((edges[id] % td) == 0);
      nl = level[id];
      for (int ch = 0; ch < 8; ch++) begin
        if (seen2[id][ch] == level[id][ch]) begin
          run[id][ch] = 0;
        end else if (tick_now) begin
          run[id][ch] = run[id][ch] + 1;
          if (run[id][ch] == st) begin
            nl[ch] = seen2[id][ch];
            run[id][ch] = 0;
          end
        end
      end
      e.lvl  = nl;
      e.rise = nl & ~level[id];
      e.fall = ~nl & level[id];
      level[id] = nl;
      seen2[id] = seen1[id];
      seen1[id] = raw ^ mask;
      edges[id] = edges[id] + 1;
      e.tick = ((edges[id] % td) == 0);
    end
  endtask

  // Drive inputs for the next edge, queue what both DUTs must show after it,
  // then advance to just past that edge.
  task automatic apply(input logic [7:0] ra, input logic rsa,
                       input logic [7:0] rb, input logic rsb);
    exp_t e;
    raw_a = ra;
    rst_a = rsa;
    raw_b = rb;
    rst_b = rsb;
    model_edge(0, 1, 4, 8'h01, ra, rsa, e);
    q_a.push_back(e);
    model_edge(1, 5, 3, 8'h01, rb, rsb, e);
    q_b.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [7:0] ra, input logic [7:0] rb, input int n);
    for (int i = 0; i < n; i++) apply(ra, 1'b0, rb, 1'b0);
  endtask

  function automatic void check(input string name, input exp_t e,
                                input logic [7:0] l, input logic [7:0] r,
                                input logic [7:0] f, input logic t);
    vectors++;
    if (l !== e.lvl || r !== e.rise || f !== e.fall || t !== e.tick) begin
      miscompares++;
      $display("FAIL %s @%0t: got lvl=%h rise=%h fall=%h tick=%b, expected lvl=%h rise=%h fall=%h tick=%b",
               name, $time, l, r, f, t, e.lvl, e.rise, e.fall, e.tick);
    end
  endfunction

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("cfgA", e, lvl_a, rise_a, fall_a, tick_a);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("cfgB", e, lvl_b, rise_b, fall_b, tick_b);
    end
  end

  initial begin
    logic [7:0] ra, rb;
    logic       ra_rst, rb_rst;

    // Reset and idle: BTN_N released (raw 1) must agree with reset state.
    for (int i = 0; i < 3; i++) apply(8'h01, 1'b1, 8'h01, 1'b1);
    hold(8'h01, 8'h01, 50);

    // Press/release latency on channel 1.
    hold(8'h03, 8'h01, 10);
    hold(8'h01, 8'h01, 10);

    // Glitch rejection on channel 2, then a long-enough pulse.
    hold(8'h05, 8'h01, 3);
    hold(8'h01, 8'h01, 1);
    hold(8'h05, 8'h01, 3);
    hold(8'h01, 8'h01, 10);
    hold(8'h05, 8'h01, 6);
    hold(8'h01, 8'h01, 10);

    // Active-low channel 0: press (raw 0) then release.
    hold(8'h00, 8'h01, 10);
    hold(8'h01, 8'h01, 10);

    // Simultaneous channels: 0x01 -> 0xF0 updates five levels at once.
    hold(8'hF0, 8'h01, 10);
    hold(8'h01, 8'h01, 10);

    // Prescaled config: change pending for at most two ticks, then reset.
    hold(8'h01, 8'h10, 11);
    for (int i = 0; i < 2; i++) apply(8'h01, 1'b0, 8'h10, 1'b1);
    hold(8'h01, 8'h10, 30);
    hold(8'h01, 8'h01, 30);

    // Randomised phase: bits flip with per-config probabilities, occasional
    // independent resets.
    ra = 8'h01;
    rb = 8'h01;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 9) == 0)  ra[b] = ~ra[b];
        if ($urandom_range(0, 29) == 0) rb[b] = ~rb[b];
      end
      ra_rst = ($urandom_range(0, 399) == 0);
      rb_rst = ($urandom_range(0, 399) == 0);
      apply(ra, ra_rst, rb, rb_rst);
    end

    // Let the monitor consume the final expectations.
    @(negedge clk);
    #1;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left, required 0/0", q_a.size(), q_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
